// File: rtl/jt900h_prefetch.sv
// Instruction prefetch queue for the JT900H: fetches 16-bit words into a
// 4-byte queue and presents the next two opcode bytes to the control unit.
module jt900h_prefetch #(
  parameter logic [23:0] RSTPC = 24'hFFFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        pc_ld,
  input  logic [23:0] pc_new,
  input  logic [1:0]  adv,
  output logic [15:0] md,
  output logic [2:0]  qcnt,
  output logic [23:0] pc,
  output logic        bus_rd,
  output logic [23:0] bus_addr,
  input  logic        bus_ack,
  input  logic [15:0] bus_din
);

  logic [3:0][7:0] q_q, q_d;
  logic [2:0]      qcnt_q, qcnt_d, base;
  logic [23:0]     pc_q, pc_d, fa_q, fa_d, addr_q, addr_d;
  logic            skip_q, skip_d, drop_q, drop_d, rd_q, rd_d;
  logic [1:0]      n;
  logic            ack;

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    ack    = bus_ack & rd_q;
    n      = (adv == 2'd3) ? 2'd0 : adv;
    if ({1'b0, n} > qcnt_q) n = 2'd0;
    base   = qcnt_q - {1'b0, n};
    q_d    = q_q >> {n, 3'b000};
    qcnt_d = base;
    pc_d   = pc_q + {22'd0, n};
    fa_d   = fa_q;
    skip_d = skip_q;
    drop_d = drop_q;
    rd_d   = rd_q;
    addr_d = addr_q;
    if (pc_ld) begin
      q_d    = q_q;
      qcnt_d = 3'd0;
      pc_d   = pc_new;
      fa_d   = {pc_new[23:1], 1'b0};
      skip_d = pc_new[0];
      // An in-flight read cannot be cancelled on the bus; its data is
      // discarded when it returns, unless it returns right now.
      if (ack) begin
        rd_d   = 1'b0;
        drop_d = 1'b0;
      end else if (rd_q) begin
        drop_d = 1'b1;
      end
    end else begin
      if (ack) begin
        rd_d = 1'b0;
        if (drop_q) begin
          drop_d = 1'b0;
        end else begin
          fa_d = fa_q + 24'd2;
          if (skip_q) begin
            q_d[base[1:0]] = bus_din[15:8];
            qcnt_d         = base + 3'd1;
            skip_d         = 1'b0;
          end else begin
            q_d[base[1:0]]        = bus_din[7:0];
            q_d[base[1:0] + 2'd1] = bus_din[15:8];
            qcnt_d                = base + 3'd2;
          end
        end
      end
      // Room for a whole word after this cycle's pop and push.
      if (!rd_q && qcnt_d <= 3'd2) begin
        rd_d   = 1'b1;
        addr_d = fa_q;
      end
    end
  end

  // NOTE: the queue storage is reset too, because md must read zero out of
  // reset; it is only four bytes of flops, not a RAM.
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      qcnt_q <= 3'd0;
      pc_q   <= RSTPC;
      fa_q   <= {RSTPC[23:1], 1'b0};
      skip_q <= RSTPC[0];
      drop_q <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 24'd0;
    end else if (cen) begin
      q_q    <= q_d;
      qcnt_q <= qcnt_d;
      pc_q   <= pc_d;
      fa_q   <= fa_d;
      skip_q <= skip_d;
      drop_q <= drop_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
    end
  end

  assign md       = q_q[1:0];
  assign qcnt     = qcnt_q;
  assign pc       = pc_q;
  assign bus_rd   = rd_q;
  assign bus_addr = addr_q;

endmodule

// File: tb/tb_jt900h_prefetch.sv
// Bench for jt900h_prefetch: directed scenarios plus a randomized run checked
// against a byte-queue reference model.
module tb_jt900h_prefetch;

  localparam logic [23:0] RSTPC = 24'hFFFF00;

  logic        clk = 1'b0;
  logic        rst, cen, pc_ld, bus_ack;
  logic [23:0] pc_new;
  logic [1:0]  adv;
  logic [15:0] bus_din;
  logic [15:0] md;
  logic [2:0]  qcnt;
  logic [23:0] pc, bus_addr;
  logic        bus_rd;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0]  mq[$];
  logic [23:0] m_pc, m_fa, m_addr;
  bit          m_skip, m_drop, m_rd;

  jt900h_prefetch #(.RSTPC(RSTPC)) dut (
    .clk(clk), .rst(rst), .cen(cen), .pc_ld(pc_ld), .pc_new(pc_new),
    .adv(adv), .md(md), .qcnt(qcnt), .pc(pc), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_din(bus_din)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    mq.delete();
    m_pc   = RSTPC;
    m_fa   = {RSTPC[23:1], 1'b0};
    m_skip = RSTPC[0];
    m_drop = 1'b0;
    m_rd   = 1'b0;
    m_addr = 24'd0;
  endtask

  // One enabled clock edge expressed in terms of the byte queue.
  task automatic model_tick();
    int n;
    bit ack, was_rd;
    if (!cen) return;
    was_rd = m_rd;
    ack    = bus_ack && m_rd;
    n      = (adv == 2'd3) ? 0 : int'(adv);
    if (n > mq.size()) n = 0;
    if (pc_ld) begin
      mq.delete();
      m_pc   = pc_new;
      m_fa   = {pc_new[23:1], 1'b0};
      m_skip = pc_new[0];
      if (ack) begin
        m_rd   = 1'b0;
        m_drop = 1'b0;
      end else if (m_rd) begin
        m_drop = 1'b1;
      end
    end else begin
      repeat (n) void'(mq.pop_front());
      m_pc = m_pc + 24'(n);
      if (ack) begin
        m_rd = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else begin
          m_fa = m_fa + 24'd2;
          if (m_skip) begin
            mq.push_back(bus_din[15:8]);
            m_skip = 1'b0;
          end else begin
            mq.push_back(bus_din[7:0]);
            mq.push_back(bus_din[15:8]);
          end
        end
      end
      if (!was_rd && mq.size() <= 2) begin
        m_rd   = 1'b1;
        m_addr = m_fa;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_tick();
    #1;
  endtask

  task automatic test_reset();
    checks++; if (qcnt !== 3'd0) begin errors++; $display("FAIL reset_qcnt: got %0d want 0", qcnt); end
    checks++; if (md !== 16'h0000) begin errors++; $display("FAIL reset_md: got %h want 0000", md); end
    checks++; if (pc !== RSTPC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RSTPC); end
    checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL reset_bus_rd: got %b want 0", bus_rd); end
    rst = 1'b0;
    step();
    checks++; if (bus_rd !== 1'b1 || bus_addr !== 24'hFFFF00) begin errors++; $display("FAIL first_req: got rd=%b addr=%h want rd=1 addr=ffff00", bus_rd, bus_addr); end
    bus_ack = 1'b1; bus_din = 16'h3412;
    step();
    bus_ack = 1'b0;
    checks++; if (md !== 16'h3412 || qcnt !== 3'd2 || pc !== 24'hFFFF00) begin errors++; $display("FAIL first_fill: got md=%h qcnt=%0d pc=%h want md=3412 qcnt=2 pc=ffff00", md, qcnt, pc); end
    checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL first_fill_rd: got %b want 0", bus_rd); end
  endtask

  task automatic test_jump_idle();
    pc_ld = 1'b1; pc_new = 24'h000101;
    step();
    pc_ld = 1'b0;
    checks++; if (qcnt !== 3'd0 || pc !== 24'h000101 || bus_rd !== 1'b0) begin errors++; $display("FAIL jump_idle_flush: got qcnt=%0d pc=%h rd=%b want 0/000101/0", qcnt, pc, bus_rd); end
    step();
    checks++; if (bus_rd !== 1'b1 || bus_addr !== 24'h000100) begin errors++; $display("FAIL jump_idle_req: got rd=%b addr=%h want 1/000100", bus_rd, bus_addr); end
    bus_ack = 1'b1; bus_din = 16'h5645;
    step();
    bus_ack = 1'b0;
    checks++; if (qcnt !== 3'd1 || md[7:0] !== 8'h56 || pc !== 24'h000101) begin errors++; $display("FAIL jump_idle_odd: got qcnt=%0d md_lo=%h pc=%h want 1/56/000101", qcnt, md[7:0], pc); end
  endtask

  task automatic test_jump_outstanding();
    step();
    checks++; if (bus_rd !== 1'b1 || bus_addr !== 24'h000102) begin errors++; $display("FAIL jo_req: got rd=%b addr=%h want 1/000102", bus_rd, bus_addr); end
    pc_ld = 1'b1; pc_new = 24'h123456;
    step();
    pc_ld = 1'b0;
    checks++; if (bus_rd !== 1'b1 || bus_addr !== 24'h000102 || qcnt !== 3'd0 || pc !== 24'h123456) begin errors++; $display("FAIL jo_hold: got rd=%b addr=%h qcnt=%0d pc=%h", bus_rd, bus_addr, qcnt, pc); end
    repeat (2) step();
    bus_ack = 1'b1; bus_din = 16'hAAAA;
    step();
    bus_ack = 1'b0;
    checks++; if (qcnt !== 3'd0 || bus_rd !== 1'b0) begin errors++; $display("FAIL jo_stale_dropped: got qcnt=%0d rd=%b want 0/0", qcnt, bus_rd); end
    step();
    checks++; if (bus_rd !== 1'b1 || bus_addr !== 24'h123456) begin errors++; $display("FAIL jo_new_req: got rd=%b addr=%h want 1/123456", bus_rd, bus_addr); end
    bus_ack = 1'b1; bus_din = 16'hBBCC;
    step();
    bus_ack = 1'b0;
    checks++; if (qcnt !== 3'd2 || md !== 16'hBBCC || pc !== 24'h123456) begin errors++; $display("FAIL jo_fill: got qcnt=%0d md=%h pc=%h want 2/bbcc/123456", qcnt, md, pc); end
  endtask

  task automatic test_fill_and_adv();
    step();
    bus_ack = 1'b1; bus_din = 16'h2211;
    step();
    bus_ack = 1'b0;
    checks++; if (qcnt !== 3'd4 || md !== 16'hBBCC) begin errors++; $display("FAIL fill_full: got qcnt=%0d md=%h want 4/bbcc", qcnt, md); end
    step();
    checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL fill_no_req: got rd=%b want 0", bus_rd); end
    adv = 2'd2;
    step();
    checks++; if (qcnt !== 3'd2 || md !== 16'h2211 || pc !== 24'h123458 || bus_rd !== 1'b1 || bus_addr !== 24'h12345A) begin errors++; $display("FAIL adv_req: got qcnt=%0d md=%h pc=%h rd=%b addr=%h", qcnt, md, pc, bus_rd, bus_addr); end
    bus_ack = 1'b1; bus_din = 16'h4433;
    step();
    bus_ack = 1'b0; adv = 2'd0;
    checks++; if (qcnt !== 3'd2 || md !== 16'h4433 || pc !== 24'h12345A) begin errors++; $display("FAIL pop_push: got qcnt=%0d md=%h pc=%h want 2/4433/12345a", qcnt, md, pc); end
  endtask

  task automatic test_wrap();
    pc_ld = 1'b1; pc_new = 24'hFFFFFE;
    step();
    pc_ld = 1'b0;
    step();
    bus_ack = 1'b1; bus_din = 16'h6655;
    step();
    bus_ack = 1'b0; adv = 2'd2;
    step();
    adv = 2'd0;
    checks++; if (pc !== 24'h000000 || qcnt !== 3'd0) begin errors++; $display("FAIL wrap_pc: got pc=%h qcnt=%0d want 000000/0", pc, qcnt); end
    checks++; if (bus_rd !== 1'b1 || bus_addr !== 24'h000000) begin errors++; $display("FAIL wrap_addr: got rd=%b addr=%h want 1/000000", bus_rd, bus_addr); end
    bus_ack = 1'b1; bus_din = 16'h8877;
    step();
    bus_ack = 1'b0;
    checks++; if (md !== 16'h8877 || qcnt !== 3'd2) begin errors++; $display("FAIL wrap_fill: got md=%h qcnt=%0d want 8877/2", md, qcnt); end
  endtask

  task automatic test_error_and_cen();
    adv = 2'd1;
    step();
    adv = 2'd2;
    step();
    adv = 2'd0;
    checks++; if (qcnt !== 3'd1 || pc !== 24'h000001 || md[7:0] !== 8'h88) begin errors++; $display("FAIL over_consume: got qcnt=%0d pc=%h md_lo=%h want 1/000001/88", qcnt, pc, md[7:0]); end
    cen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_ack = (i % 2 == 0); bus_din = 16'hDEAD; adv = 2'd1;
      step();
    end
    bus_ack = 1'b0; adv = 2'd0;
    checks++; if (qcnt !== 3'd1 || pc !== 24'h000001 || bus_rd !== 1'b1 || bus_addr !== 24'h000002) begin errors++; $display("FAIL cen_frozen: got qcnt=%0d pc=%h rd=%b addr=%h", qcnt, pc, bus_rd, bus_addr); end
    cen = 1'b1;
    step();
    checks++; if (qcnt !== 3'd1 || bus_rd !== 1'b1) begin errors++; $display("FAIL cen_ack_ignored: got qcnt=%0d rd=%b want 1/1", qcnt, bus_rd); end
    bus_ack = 1'b1; bus_din = 16'h0A09;
    step();
    bus_ack = 1'b0;
    checks++; if (qcnt !== 3'd3 || md !== 16'h0988) begin errors++; $display("FAIL cen_resume: got qcnt=%0d md=%h want 3/0988", qcnt, md); end
  endtask

  task automatic test_reset_mid_request();
    adv = 2'd2;
    step();
    adv = 2'd0;
    checks++; if (bus_rd !== 1'b1) begin errors++; $display("FAIL rmid_pre: got rd=%b want 1", bus_rd); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_rd !== 1'b0 || qcnt !== 3'd0 || pc !== RSTPC) begin errors++; $display("FAIL rmid_async: got rd=%b qcnt=%0d pc=%h", bus_rd, qcnt, pc); end
    model_reset();
    bus_ack = 1'b1; bus_din = 16'hFFFF;
    step();
    rst = 1'b0;
    step();
    bus_ack = 1'b0;
    checks++; if (qcnt !== 3'd0 || bus_rd !== 1'b1 || bus_addr !== RSTPC) begin errors++; $display("FAIL rmid_after: got qcnt=%0d rd=%b addr=%h", qcnt, bus_rd, bus_addr); end
  endtask

  task automatic test_random();
    int lim;
    for (int c = 0; c < 3000; c++) begin
      cen   = ($urandom_range(0, 9) != 0);
      pc_ld = ($urandom_range(0, 24) == 0);
      pc_new = 24'($urandom);
      if ($urandom_range(0, 7) == 0) adv = 2'($urandom_range(0, 3));
      else begin
        lim = (mq.size() > 2) ? 2 : mq.size();
        adv = 2'($urandom_range(0, lim));
      end
      bus_ack = bus_rd ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      bus_din = 16'($urandom);
      step();
      checks++; if (qcnt !== 3'(mq.size())) begin errors++; $display("FAIL rand_qcnt c=%0d: got %0d want %0d", c, qcnt, mq.size()); end
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc c=%0d: got %h want %h", c, pc, m_pc); end
      checks++; if (bus_rd !== m_rd) begin errors++; $display("FAIL rand_rd c=%0d: got %b want %b", c, bus_rd, m_rd); end
      if (m_rd) begin
        checks++; if (bus_addr !== m_addr) begin errors++; $display("FAIL rand_addr c=%0d: got %h want %h", c, bus_addr, m_addr); end
      end
      if (mq.size() >= 1) begin
        checks++; if (md[7:0] !== mq[0]) begin errors++; $display("FAIL rand_md_lo c=%0d: got %h want %h", c, md[7:0], mq[0]); end
      end
      if (mq.size() >= 2) begin
        checks++; if (md[15:8] !== mq[1]) begin errors++; $display("FAIL rand_md_hi c=%0d: got %h want %h", c, md[15:8], mq[1]); end
      end
    end
    cen = 1'b1; pc_ld = 1'b0; adv = 2'd0; bus_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; pc_ld = 1'b0; pc_new = 24'd0;
    adv = 2'd0; bus_ack = 1'b0; bus_din = 16'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_jump_idle();
    test_jump_outstanding();
    test_fill_and_adv();
    test_wrap();
    test_error_and_cen();
    test_reset_mid_request();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
